// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: shares SRAM port 0 between host loader (A) and FPU core (B)
// Ports: clk (also macro clk0), rst_l sync active-low reset.
//   a_*/b_*: req/we/wmask/addr/wdata command in, gnt (combinational) out,
//            rvalid/rdata read return 3 cycles after the grant.
//   sram_*0: registered macro port-0 command, sram_dout0 macro read data.
// Macro SRAM_ARB_ROUND_ROBIN_EN: round-robin on contention, else A beats B.
module sram_port0_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);
  logic a_win, hs, we;
  logic rd1, t1, rd2, t2;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic rr_b;
  // Flips only when both request, so the loser of a contention wins the next one.
  always_ff @(posedge clk)
    rr_b <= !rst_l ? 1'b0 : (a_req & b_req) ? ~rr_b : rr_b;
  assign a_win = ~rr_b;
`else
  assign a_win = 1'b1;
`endif
  assign a_gnt = rst_l & a_req & (~b_req | a_win);
  assign b_gnt = rst_l & b_req & ~(a_req & a_win);
  assign hs    = a_gnt | b_gnt;
  assign we    = b_gnt ? b_we : a_we;
  // rd1/t1 track the read sitting at the macro; rd2/t2 the read whose dout is ready.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      {rd1, t1, rd2, t2} <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      sram_csb0 <= ~hs;
      sram_web0 <= ~(hs & we);
      if (hs) begin
        sram_addr0  <= b_gnt ? b_addr : a_addr;
        sram_wmask0 <= we ? (b_gnt ? b_wmask : a_wmask) : '0;
        sram_din0   <= we ? (b_gnt ? b_wdata : a_wdata) : '0;
      end
      rd1 <= hs & ~we;
      t1  <= b_gnt;
      rd2 <= rd1;
      t2  <= t1;
      a_rvalid <= rd2 & ~t2;
      b_rvalid <= rd2 & t2;
      if (rd2 & ~t2) a_rdata <= sram_dout0;
      if (rd2 & t2) b_rdata <= sram_dout0;
    end
  end
endmodule

// File: doc/sram_port0_arbiter.md
Name: sram_port0_arbiter

Overview:
- Shares the single read/write port (port 0) of the 32x256 sky130 SRAM macro between two requesters.
- Requester A is the Wishbone/host loader; requester B is the FPU core.
- Registers every macro command, tracks in-flight reads in a fixed-latency pipeline, and returns read data to the originating requester.
- Sits directly beside the SRAM macro instance in the FPU top; the macro's read-only port 1 is not touched by this block.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 8, word address width
- NUM_WMASKS, 4, byte-lane write mask width (DATA_WIDTH/8)

Ports:
- clk  in  1  single clock; also drives macro clk0
- rst_l  in  1  synchronous active-low reset
- a_req  in  1  requester A command valid; held until granted
- a_we  in  1  1 = write, 0 = read
- a_wmask  in  NUM_WMASKS  byte-lane enables (writes only)
- a_addr  in  ADDR_WIDTH  word address
- a_wdata  in  DATA_WIDTH  write data
- a_gnt  out  1  command accepted this cycle (combinational)
- a_rvalid  out  1  one-cycle pulse: read data valid
- a_rdata  out  DATA_WIDTH  read data
- b_req, b_we, b_wmask, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
- sram_csb0  out  1  macro chip select, active low
- sram_web0  out  1  macro write enable, active low
- sram_wmask0  out  NUM_WMASKS  macro write mask
- sram_addr0  out  ADDR_WIDTH  macro address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_dout0  in  DATA_WIDTH  macro read data

Behaviour:
- Reset (rst_l low at posedge):
  - sram_csb0=1, sram_web0=1; sram_wmask0, sram_addr0, sram_din0 = 0.
  - a_rvalid=b_rvalid=0; a_rdata=b_rdata=0.
  - Pipeline valid bits cleared; round-robin pointer = A.
- Handshake:
  - A requester's command transfers at the posedge where req&gnt=1.
  - At most one gnt per cycle; gnt is never asserted while rst_l=0.
  - Throughput is one command per cycle, back-to-back, with no bubbles.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: the winner is chosen by policy (see Optional Feature).
- Stage S1 (cycle T+1 after handshake in T):
  - sram_csb0=0, sram_web0=~we.
  - addr, wmask, din registered from the winner.
  - For reads, sram_wmask0 = 0 and din = 0.
  - With no handshake in T: sram_csb0=1, sram_web0=1, other outputs hold.
- Macro timing: the macro samples at the end of T+1 and updates dout0 on the following negedge.
- Stage S2 (end of T+2): for reads, sram_dout0 is captured into the rdata register of the granted requester.
- Stage S3 (cycle T+3): xx_rvalid=1 for exactly one cycle.
  - Fixed read latency: 3 cycles from handshake to rvalid.
  - The other requester's rdata holds its previous value.
- Writes: produce no rvalid; complete inside the macro on the negedge of T+2.
- Ordering: a read granted the cycle after a write to the same address returns the new data. Write and read are both issued through the same port and the macro's write precedes its read-out.
- Pipeline tag: each in-flight read carries a 1-bit owner tag through S1–S3. At most 3 commands are in flight; no backpressure exists on rvalid, so requesters must accept it.
- Reset mid-operation: all in-flight tags are dropped and no rvalid is produced. A write already presented to the macro in the reset cycle may still land.
- Address wrap: none; addresses are used as-is (0..255).

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - On contention, grant the requester that did not win the last contended grant.
  - The pointer updates only on contended grants.
- Undefined: fixed priority, with A always beating B. The pointer register is not present.

Test Plan:
- Reset, then A writes addr 0x10 data 0xDEADBEEF, wmask 4'hF; later A reads 0x10 -> a_rvalid exactly 3 cycles after the read grant, a_rdata=0xDEADBEEF; b_rvalid stays 0.
- Byte mask: B writes 0x20 = 0x11223344 (wmask F), then writes 0xAABBCCDD with wmask 4'b0101, then reads -> b_rdata=0x11BB33DD.
- Back-to-back: A reads 0x00..0x03 on four consecutive cycles -> four consecutive a_rvalid pulses with data in order and no idle cycles.
- Contention: a_req=b_req=1 held for 4 cycles -> with SRAM_ARB_ROUND_ROBIN_EN, grants alternate A,B,A,B; without it, A,A,A,A and b_gnt=0 throughout.
- Write-then-read: A writes 0x05=0x12345678; B reads 0x05 in the next cycle -> b_rdata=0x12345678.
- Reset mid-flight: A reads 0x10, and rst_l is pulled low 1 cycle after the grant -> no a_rvalid; sram_csb0=1 the cycle after reset; normal operation resumes after rst_l rises.
